// File: rtl/mips32_shift_pkg.sv
// Shared types and sizes for the sequential MIPS32 shift path.
package mips32_shift_pkg;
  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sh_state_e;
endpackage

// File: rtl/mips32_shift_step.sv
// One-bit shift/rotate step; combinational so it can be shared with other
// bit-serial datapaths.
module mips32_shift_step
  import mips32_shift_pkg::*;
(
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_t        op_i,
  output logic [WIDTH-1:0] data_o
);
  always_comb begin
    data_o = data_i;
    case (op_i)
      SH_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      SH_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
      SH_SRA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      SH_ROL:  data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
      default: data_o = data_i;
    endcase
  end
endmodule

// File: rtl/mips32_seq_shifter.sv
// Handshaked shifter that performs one bit position per clock; the result
// register is only updated on entry to DONE so it holds across new operations.
module mips32_seq_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Shift_in,
  input  logic [AMT_W-1:0] Shift_amount,
  input  logic [1:0]       Shift_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Shift_out,
  output logic             busy
);
  import mips32_shift_pkg::*;

  sh_state_e        state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  shift_op_t        op_q, op_d;
  logic [WIDTH-1:0] step_data;

  mips32_shift_step u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .data_o (step_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= SH_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = Shift_in;
          op_d   = shift_op_t'(Shift_op);
          cnt_d  = Shift_amount;
          if (Shift_amount == '0) begin
            state_d = DONE;
            res_d   = Shift_in;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = step_data;
        cnt_d  = cnt_q - AMT_W'(1);
        // Last step goes straight into the result register.
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
          res_d   = step_data;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Shift_out = res_q;
endmodule

// File: tb/tb_mips32_seq_shifter.sv
// Self-checking bench: directed table, backpressure, mid-shift reset and
// randomized operations against an arithmetic reference model.
module tb_mips32_seq_shifter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] Shift_in, Shift_out;
  logic [4:0]  Shift_amount;
  logic [1:0]  Shift_op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips32_seq_shifter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Shift_in     (Shift_in),
    .Shift_amount (Shift_amount),
    .Shift_op     (Shift_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Shift_out    (Shift_out),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input int n);
    logic signed [31:0] s;
    logic [63:0]        dd;
    s  = d;
    dd = {d, d} << n;
    case (op)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return s >>> n;
      default: return dd[63:32];
    endcase
  endfunction

  // Issue one op, check acceptance, latency and result, then hold out_ready
  // low for `hold` DONE cycles (optionally poking in_valid) before draining.
  task automatic do_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] amt,
                       input logic [31:0] exp, input int hold, input bit poke);
    int lat;
    logic [31:0] first;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; Shift_in = d; Shift_amount = amt; Shift_op = op;
    @(negedge clk);
    in_valid = 1'b0;
    Shift_in = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("busy_shift", 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      chk("timeout_out_valid", 32'(out_valid), 32'd1);
      return;
    end
    chk("latency", 32'(lat), 32'(amt) + 32'd1);
    chk("result", Shift_out, exp);
    first = Shift_out;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        in_valid = 1'b1; Shift_in = ~d; Shift_amount = 5'd3; Shift_op = 2'b11;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_stable", Shift_out, first);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    chk("hold_after_done", Shift_out, first);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    tbl[1] = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
    tbl[2] = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
    tbl[3] = '{2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003};
    tbl[4] = '{2'b11, 32'h1234_5678, 5'd16, 32'h5678_1234};
    tbl[5] = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[6] = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[7] = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[8] = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Shift_in = '0; Shift_amount = '0; Shift_op = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_shift_out", Shift_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) do_op(tbl[i].op, tbl[i].data, tbl[i].amt, tbl[i].exp, 0, 1'b0);

    // Backpressure with an ignored in_valid pulse, then a follow-on op.
    do_op(2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 10, 1'b1);
    do_op(2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, 0, 1'b0);

    // Reset three cycles into a long SLL.
    @(negedge clk);
    in_valid = 1'b1; Shift_in = 32'h0000_00FF; Shift_amount = 5'd20; Shift_op = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_shift_out", Shift_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("no_spurious_valid", 32'(seen), 32'd0);
    end

    // Randomized operations with random backpressure.
    for (int k = 0; k < 1000; k++) begin
      logic [1:0]  op;
      logic [31:0] d;
      logic [4:0]  amt;
      op  = 2'($urandom_range(0, 3));
      d   = $urandom;
      amt = 5'($urandom_range(0, 31));
      do_op(op, d, amt, model(op, d, int'(amt)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
